// File: rtl/axi4_lite_addr_map_package.sv
`default_nettype none
//==============================================================================
// Module   : axi4_lite_addr_map_package
// Brief    : Response codes, word-index decode bounds and FSM state encodings
//            shared by the AXI4-Lite register file.
// Revision : 1.0
//==============================================================================
package axi4_lite_addr_map_package;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int c_IDX_LSB   = 2;
    localparam int c_IDX_MSB   = 11;
    localparam int c_IDX_WIDTH = c_IDX_MSB - c_IDX_LSB + 1;

    typedef enum logic [1:0] {
        W_IDLE      = 2'd0,
        W_HAVE_ADDR = 2'd1,
        W_HAVE_DATA = 2'd2,
        W_RESP      = 2'd3
    } w_state_t;

    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_RESP = 1'b1
    } r_state_t;

endpackage
`default_nettype wire

// File: rtl/axi4_lite_strb_merge.sv
`default_nettype none
//==============================================================================
// Module   : axi4_lite_strb_merge
// Brief    : Byte-lane merge of a new word into an old word under a write strobe.
// Revision : 1.0
//==============================================================================
module axi4_lite_strb_merge #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0]   i_old_word,
    input  logic [DATA_WIDTH-1:0]   i_new_word,
    input  logic [DATA_WIDTH/8-1:0] i_strb,
    output logic [DATA_WIDTH-1:0]   o_merged
);

    for (genvar k = 0; k < DATA_WIDTH / 8; k++) begin : g_lane
        assign o_merged[8*k +: 8] = i_strb[k] ? i_new_word[8*k +: 8] : i_old_word[8*k +: 8];
    end

endmodule
`default_nettype wire

// File: rtl/axi4_lite_regfile_slave.sv
`default_nettype none
//==============================================================================
// Module   : axi4_lite_regfile_slave
// Brief    : AXI4-Lite slave exposing NUM_REGS 32-bit registers with independent
//            write/read FSMs and SLVERR on unmapped word indices.
// Revision : 1.0
//==============================================================================
module axi4_lite_regfile_slave
    import axi4_lite_addr_map_package::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [ADDR_WIDTH-1:0]          s_awaddr,
    input  logic                           s_awvalid,
    output logic                           s_awready,
    input  logic [DATA_WIDTH-1:0]          s_wdata,
    input  logic [DATA_WIDTH/8-1:0]        s_wstrb,
    input  logic                           s_wvalid,
    output logic                           s_wready,
    output logic [1:0]                     s_bresp,
    output logic                           s_bvalid,
    input  logic                           s_bready,
    input  logic [ADDR_WIDTH-1:0]          s_araddr,
    input  logic                           s_arvalid,
    output logic                           s_arready,
    output logic [DATA_WIDTH-1:0]          s_rdata,
    output logic [1:0]                     s_rresp,
    output logic                           s_rvalid,
    input  logic                           s_rready,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q
);

    localparam int                 c_CNT_W    = c_IDX_WIDTH + 1;
    localparam logic [c_CNT_W-1:0] c_NUM_REGS = c_CNT_W'(NUM_REGS);

    function automatic logic is_mapped(input logic [c_IDX_WIDTH-1:0] idx);
        return {1'b0, idx} < c_NUM_REGS;
    endfunction

    logic [DATA_WIDTH-1:0]   r_regs [NUM_REGS];

    w_state_t                r_wstate;
    logic [c_IDX_WIDTH-1:0]  r_widx;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [DATA_WIDTH/8-1:0] r_wstrb;
    logic                    r_bvalid;
    logic [1:0]              r_bresp;

    r_state_t                r_rstate;
    logic                    r_rvalid;
    logic [DATA_WIDTH-1:0]   r_rdata;
    logic [1:0]              r_rresp;

    logic                    w_aw_hs;
    logic                    w_w_hs;
    logic                    w_ar_hs;
    logic [c_IDX_WIDTH-1:0]  w_aw_idx;
    logic [c_IDX_WIDTH-1:0]  w_ar_idx;
    logic                    w_commit;
    logic [c_IDX_WIDTH-1:0]  w_cidx;
    logic [DATA_WIDTH-1:0]   w_cdata;
    logic [DATA_WIDTH/8-1:0] w_cstrb;
    logic [DATA_WIDTH-1:0]   w_old_word;
    logic [DATA_WIDTH-1:0]   w_merged;
    logic [DATA_WIDTH-1:0]   w_rd_word;
    logic                    w_unused_addr;

    // Readies depend only on state and rst, never on any VALID input.
    assign s_awready = !rst && (r_wstate == W_IDLE || r_wstate == W_HAVE_DATA);
    assign s_wready  = !rst && (r_wstate == W_IDLE || r_wstate == W_HAVE_ADDR);
    assign s_arready = !rst && (r_rstate == R_IDLE);

    assign s_bvalid = r_bvalid;
    assign s_bresp  = r_bresp;
    assign s_rvalid = r_rvalid;
    assign s_rdata  = r_rdata;
    assign s_rresp  = r_rresp;

    assign w_aw_hs  = s_awvalid && s_awready;
    assign w_w_hs   = s_wvalid && s_wready;
    assign w_ar_hs  = s_arvalid && s_arready;
    assign w_aw_idx = s_awaddr[c_IDX_MSB:c_IDX_LSB];
    assign w_ar_idx = s_araddr[c_IDX_MSB:c_IDX_LSB];

    assign w_unused_addr = ^{s_awaddr, s_araddr};

    // The write commits on the cycle whichever half arrives last is handshaken.
    always_comb begin
        w_commit = 1'b0;
        w_cidx   = r_widx;
        w_cdata  = r_wdata;
        w_cstrb  = r_wstrb;
        case (r_wstate)
            W_IDLE: begin
                if (w_aw_hs && w_w_hs) begin
                    w_commit = 1'b1;
                    w_cidx   = w_aw_idx;
                    w_cdata  = s_wdata;
                    w_cstrb  = s_wstrb;
                end
            end
            W_HAVE_ADDR: begin
                if (w_w_hs) begin
                    w_commit = 1'b1;
                    w_cdata  = s_wdata;
                    w_cstrb  = s_wstrb;
                end
            end
            W_HAVE_DATA: begin
                if (w_aw_hs) begin
                    w_commit = 1'b1;
                    w_cidx   = w_aw_idx;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        w_old_word = '0;
        w_rd_word  = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (w_cidx == c_IDX_WIDTH'(i)) w_old_word = r_regs[i];
            if (w_ar_idx == c_IDX_WIDTH'(i)) w_rd_word = r_regs[i];
        end
    end

    axi4_lite_strb_merge #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_strb_merge (
        .i_old_word (w_old_word),
        .i_new_word (w_cdata),
        .i_strb     (w_cstrb),
        .o_merged   (w_merged)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wstate <= W_IDLE;
            r_widx   <= '0;
            r_wdata  <= '0;
            r_wstrb  <= '0;
            r_bvalid <= 1'b0;
            r_bresp  <= RESP_OKAY;
        end else begin
            case (r_wstate)
                W_IDLE: begin
                    if (w_aw_hs && !w_w_hs) begin
                        r_widx   <= w_aw_idx;
                        r_wstate <= W_HAVE_ADDR;
                    end else if (w_w_hs && !w_aw_hs) begin
                        r_wdata  <= s_wdata;
                        r_wstrb  <= s_wstrb;
                        r_wstate <= W_HAVE_DATA;
                    end
                end
                W_RESP: begin
                    if (s_bready) begin
                        r_bvalid <= 1'b0;
                        r_wstate <= W_IDLE;
                    end
                end
                default: ;
            endcase
            if (w_commit) begin
                r_wstate <= W_RESP;
                r_bvalid <= 1'b1;
                r_bresp  <= is_mapped(w_cidx) ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

    // Unmapped indices never match a register, so those writes are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
        end else if (w_commit) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (w_cidx == c_IDX_WIDTH'(i)) r_regs[i] <= w_merged;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rstate <= R_IDLE;
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_rresp  <= RESP_OKAY;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    if (w_ar_hs) begin
                        r_rstate <= R_RESP;
                        r_rvalid <= 1'b1;
                        r_rdata  <= is_mapped(w_ar_idx) ? w_rd_word : '0;
                        r_rresp  <= is_mapped(w_ar_idx) ? RESP_OKAY : RESP_SLVERR;
                    end
                end
                R_RESP: begin
                    if (s_rready) begin
                        r_rvalid <= 1'b0;
                        r_rstate <= R_IDLE;
                    end
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg_q
        assign reg_q[DATA_WIDTH*i +: DATA_WIDTH] = r_regs[i];
    end

endmodule
`default_nettype wire

// File: tb/tb_axi4_lite_regfile_slave.sv
`default_nettype none
//==============================================================================
// Module   : tb_axi4_lite_regfile_slave
// Brief    : Directed scoreboard bench for the AXI4-Lite register file slave.
// Revision : 1.0
//==============================================================================
module tb_axi4_lite_regfile_slave;
    import axi4_lite_addr_map_package::*;

    localparam int c_AW = 32;
    localparam int c_NR = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [c_AW-1:0]   s_awaddr;
    logic              s_awvalid;
    logic              s_awready;
    logic [31:0]       s_wdata;
    logic [3:0]        s_wstrb;
    logic              s_wvalid;
    logic              s_wready;
    logic [1:0]        s_bresp;
    logic              s_bvalid;
    logic              s_bready;
    logic [c_AW-1:0]   s_araddr;
    logic              s_arvalid;
    logic              s_arready;
    logic [31:0]       s_rdata;
    logic [1:0]        s_rresp;
    logic              s_rvalid;
    logic              s_rready;
    logic [c_NR*32-1:0] reg_q;

    always #5 clk = ~clk;

    axi4_lite_regfile_slave #(
        .ADDR_WIDTH (c_AW),
        .DATA_WIDTH (32),
        .NUM_REGS   (c_NR)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .s_awaddr  (s_awaddr),
        .s_awvalid (s_awvalid),
        .s_awready (s_awready),
        .s_wdata   (s_wdata),
        .s_wstrb   (s_wstrb),
        .s_wvalid  (s_wvalid),
        .s_wready  (s_wready),
        .s_bresp   (s_bresp),
        .s_bvalid  (s_bvalid),
        .s_bready  (s_bready),
        .s_araddr  (s_araddr),
        .s_arvalid (s_arvalid),
        .s_arready (s_arready),
        .s_rdata   (s_rdata),
        .s_rresp   (s_rresp),
        .s_rvalid  (s_rvalid),
        .s_rready  (s_rready),
        .reg_q     (reg_q)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] m_regs [c_NR];
    logic [1:0]  q_bresp [$];
    logic [33:0] q_rexp  [$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp_v);
        end
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < c_NR; i++)
            check($sformatf("%s_reg%0d", tag, i), reg_q[32*i +: 32], m_regs[i]);
    endtask

    function automatic logic [31:0] model_merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                                input logic [3:0] strb);
        logic [31:0] mask;
        mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
        return (new_w & mask) | (old_w & ~mask);
    endfunction

    function automatic int word_idx(input logic [31:0] addr);
        return int'((addr >> 2) & 32'h3FF);
    endfunction

    task automatic wait_b(input int hold);
        logic [1:0] first_resp;
        logic [1:0] exp_resp;
        first_resp = s_bresp;
        for (int i = 0; i < hold; i++) begin
            tick();
            check("bvalid_hold", 32'(s_bvalid), 32'd1);
            check("bresp_stable", 32'(s_bresp), 32'(first_resp));
            check("awready_in_resp", 32'(s_awready), 32'd0);
            check("wready_in_resp", 32'(s_wready), 32'd0);
        end
        s_bready = 1'b1;
        exp_resp = (q_bresp.size() > 0) ? q_bresp.pop_front() : 2'bxx;
        check("bvalid_at_bready", 32'(s_bvalid), 32'd1);
        check("bresp", 32'(s_bresp), 32'(exp_resp));
        tick();
        s_bready = 1'b0;
        check("bvalid_cleared", 32'(s_bvalid), 32'd0);
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int w_lead, input int bready_delay);
        int cyc;
        int idx;
        bit aw_done, w_done, hs_aw, hs_w;
        idx = word_idx(addr);
        if (idx < c_NR) begin
            m_regs[idx] = model_merge(m_regs[idx], data, strb);
            q_bresp.push_back(RESP_OKAY);
        end else begin
            q_bresp.push_back(RESP_SLVERR);
        end
        s_awaddr  = addr;
        s_wdata   = data;
        s_wstrb   = strb;
        s_wvalid  = 1'b1;
        s_awvalid = (w_lead == 0);
        cyc = 0;
        aw_done = 0;
        w_done = 0;
        while (!(aw_done && w_done) && cyc < 50) begin
            hs_aw = s_awvalid && s_awready;
            hs_w  = s_wvalid && s_wready;
            tick();
            cyc++;
            if (hs_aw) begin aw_done = 1; s_awvalid = 1'b0; end
            if (hs_w)  begin w_done = 1;  s_wvalid  = 1'b0; end
            if (!aw_done && cyc >= w_lead) s_awvalid = 1'b1;
        end
        s_awvalid = 1'b0;
        s_wvalid  = 1'b0;
        check("write_handshake_done", 32'(aw_done && w_done), 32'd1);
        check("bvalid_after_hs", 32'(s_bvalid), 32'd1);
        wait_b(bready_delay);
    endtask

    task automatic do_read(input logic [31:0] addr, input int rready_delay);
        int cyc;
        int idx;
        bit done, hs;
        logic [33:0] exp_r;
        idx = word_idx(addr);
        if (idx < c_NR) q_rexp.push_back({RESP_OKAY, m_regs[idx]});
        else            q_rexp.push_back({RESP_SLVERR, 32'h0});
        s_araddr  = addr;
        s_arvalid = 1'b1;
        cyc = 0;
        done = 0;
        while (!done && cyc < 50) begin
            hs = s_arvalid && s_arready;
            tick();
            cyc++;
            if (hs) done = 1;
        end
        s_arvalid = 1'b0;
        check("ar_handshake_done", 32'(done), 32'd1);
        check("rvalid_next_cycle", 32'(s_rvalid), 32'd1);
        check("arready_busy", 32'(s_arready), 32'd0);
        exp_r = (q_rexp.size() > 0) ? q_rexp.pop_front() : 34'bx;
        for (int i = 0; i < rready_delay; i++) begin
            tick();
            check("rvalid_hold", 32'(s_rvalid), 32'd1);
            check("rdata_stable", s_rdata, exp_r[31:0]);
        end
        s_rready = 1'b1;
        check("rdata", s_rdata, exp_r[31:0]);
        check("rresp", 32'(s_rresp), 32'(exp_r[33:32]));
        tick();
        s_rready = 1'b0;
        check("rvalid_cleared", 32'(s_rvalid), 32'd0);
        check("arready_after_r", 32'(s_arready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [33:0] exp_r;
        logic [1:0]  exp_b;

        rst = 1'b1;
        s_awaddr = '0; s_awvalid = 1'b0; s_wdata = '0; s_wstrb = '0; s_wvalid = 1'b0;
        s_bready = 1'b0; s_araddr = '0; s_arvalid = 1'b0; s_rready = 1'b0;
        for (int i = 0; i < c_NR; i++) m_regs[i] = 32'h0;

        tick();
        tick();
        check("awready_in_rst", 32'(s_awready), 32'd0);
        check("wready_in_rst", 32'(s_wready), 32'd0);
        check("arready_in_rst", 32'(s_arready), 32'd0);
        rst = 1'b0;
        tick();
        check("reset_bvalid", 32'(s_bvalid), 32'd0);
        check("reset_rvalid", 32'(s_rvalid), 32'd0);
        check("reset_bresp", 32'(s_bresp), 32'd0);
        check("reset_rresp", 32'(s_rresp), 32'd0);
        check("reset_rdata", s_rdata, 32'd0);
        check("idle_awready", 32'(s_awready), 32'd1);
        check_regs("reset");

        // AW and W together
        do_write(32'h08, 32'hDEADBEEF, 4'hF, 0, 0);
        check("reg2_deadbeef", reg_q[64 +: 32], 32'hDEADBEEF);
        check_regs("aw_w_same");

        // W leads AW by three cycles, partial strobe
        do_write(32'h04, 32'h11223344, 4'hF, 0, 0);
        do_write(32'h04, 32'hAABBCCDD, 4'b0101, 3, 0);
        check("reg1_merged", reg_q[32 +: 32], 32'h11BB33DD);
        check_regs("w_first");

        // Unmapped and mapping boundary
        do_read(32'h40, 0);
        do_write(32'h40, 32'hFFFFFFFF, 4'hF, 0, 0);
        check_regs("unmapped_write");
        do_read(32'h1C, 0);
        do_read(32'h20, 1);

        // Upper and lower address bits ignored
        do_write(32'h0000_1010, 32'hCAFEF00D, 4'b1100, 0, 0);
        check("reg4_upper_lanes", reg_q[128 +: 32], 32'hCAFE0000);
        do_read(32'h13, 2);
        do_read(32'h08, 0);

        // Back-pressured B then a second write
        do_write(32'h14, 32'h0000ABCD, 4'hF, 0, 5);
        do_write(32'h18, 32'h00000055, 4'b0001, 0, 0);
        check_regs("bp_write");

        // Read handshake in the same cycle the write to that register commits
        do_write(32'h0C, 32'h5, 4'hF, 0, 0);
        s_wdata = 32'h9; s_wstrb = 4'hF; s_wvalid = 1'b1;
        check("wready_idle", 32'(s_wready), 32'd1);
        tick();
        s_wvalid  = 1'b0;
        s_awaddr  = 32'h0C; s_awvalid = 1'b1;
        s_araddr  = 32'h0C; s_arvalid = 1'b1;
        check("awready_have_data", 32'(s_awready), 32'd1);
        check("arready_concurrent", 32'(s_arready), 32'd1);
        q_rexp.push_back({RESP_OKAY, m_regs[3]});
        q_bresp.push_back(RESP_OKAY);
        m_regs[3] = 32'h9;
        tick();
        s_awvalid = 1'b0; s_arvalid = 1'b0;
        exp_r = q_rexp.pop_front();
        exp_b = q_bresp.pop_front();
        check("race_bvalid", 32'(s_bvalid), 32'd1);
        check("race_rvalid", 32'(s_rvalid), 32'd1);
        check("race_rdata_old", s_rdata, exp_r[31:0]);
        check("race_bresp", 32'(s_bresp), 32'(exp_b));
        s_bready = 1'b1; s_rready = 1'b1;
        tick();
        s_bready = 1'b0; s_rready = 1'b0;
        check("race_reg3_new", reg_q[96 +: 32], 32'h9);
        do_read(32'h0C, 0);

        // Reset while holding an address only
        s_awaddr = 32'h04; s_awvalid = 1'b1;
        check("awready_pre_abort", 32'(s_awready), 32'd1);
        tick();
        s_awvalid = 1'b0;
        check("have_addr_wready", 32'(s_wready), 32'd1);
        check("have_addr_awready", 32'(s_awready), 32'd0);
        rst = 1'b1;
        #1;
        check("abort_wready_in_rst", 32'(s_wready), 32'd0);
        check("abort_arready_in_rst", 32'(s_arready), 32'd0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < c_NR; i++) m_regs[i] = 32'h0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("abort_no_bvalid", 32'(s_bvalid), 32'd0);
        end
        check_regs("abort");
        do_write(32'h04, 32'h12345678, 4'hF, 0, 0);
        check_regs("post_abort");
        do_read(32'h04, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axi4_lite_regfile_slave.md
AXI4_LITE_REGFILE_SLAVE -- requirements
Module: axi4_lite_regfile_slave

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32: AXI address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: AXI data width; only 32 is supported.
REQ-003 SHALL have parameter NUM_REGS, default 8: number of 32-bit registers, 1..1024.
REQ-004 SHALL have clk  input  1: the single clock.
REQ-005 SHALL have rst  input  1: reset, synchronous and active-high.
REQ-006 SHALL have s_awaddr/s_awvalid/s_awready  in/in/out  ADDR_WIDTH/1/1: AW channel.
REQ-007 SHALL have s_wdata/s_wstrb/s_wvalid/s_wready  in/in/in/out  32/4/1/1: W channel.
REQ-008 SHALL have s_bresp/s_bvalid/s_bready  out/out/in  2/1/1: B channel.
REQ-009 SHALL have s_araddr/s_arvalid/s_arready  in/in/out  ADDR_WIDTH/1/1: AR channel.
REQ-010 SHALL have s_rdata/s_rresp/s_rvalid/s_rready  out/out/out/in  32/2/1/1: R channel.
REQ-011 SHALL have reg_q  output  NUM_REGS*32: register contents, reg i at bits [32i+31:32i].

Function
REQ-012 SHALL decode word index = addr[11:2]; addr[1:0] and addr bits above 11 are ignored.
REQ-013 SHALL treat index >= NUM_REGS as unmapped: response SLVERR (2'b10); otherwise OKAY (2'b00).
REQ-014 SHALL implement write FSM states W_IDLE, W_HAVE_ADDR, W_HAVE_DATA, W_RESP.
REQ-015 SHALL drive s_awready=1 in W_IDLE and W_HAVE_DATA and s_wready=1 in W_IDLE and W_HAVE_ADDR; both 0 otherwise.
REQ-016 SHALL latch AW and W independently; both in the same cycle in W_IDLE go directly to W_RESP.
REQ-017 SHALL update the register on the cycle both halves are held; only byte lanes with s_wstrb[k]=1 change; unmapped writes change nothing.
REQ-018 SHALL assert s_bvalid starting the cycle after the last of AW/W handshakes and hold it with a stable s_bresp until s_bready=1, then return to W_IDLE.
REQ-019 SHALL implement read FSM states R_IDLE, R_RESP; s_arready=1 only in R_IDLE.
REQ-020 SHALL capture register data at the AR handshake and present s_rvalid=1 the next cycle; s_rdata/s_rresp hold stable until s_rready=1.
REQ-021 SHALL return s_rdata=0 for unmapped reads.
REQ-022 SHALL let read and write FSMs run concurrently; a read handshaking in the same cycle as a write update to the same register returns the pre-write value.
REQ-023 SHALL never assert s_bvalid or s_rvalid without a preceding corresponding handshake; no combinational path from any VALID input to any READY output.
REQ-024 SHALL accept a new AR on the cycle after an R handshake (read throughput: one every 2 cycles).

Reset
REQ-025 SHALL on rst=1 at a clk edge set both FSMs to idle, s_bvalid=0, s_rvalid=0, s_bresp=0, s_rresp=0, s_rdata=0, all registers 0.
REQ-026 SHALL abort any in-flight transaction on reset mid-operation, with no register update and no response issued afterward.
REQ-027 SHALL hold s_awready, s_wready and s_arready at 0 while rst=1.

Structure
REQ-028 SHALL take the RESP_OKAY/RESP_SLVERR constants and the FSM state enums from axi4_lite_addr_map_package.
REQ-029 SHALL implement the byte-strobe merge as sub-module axi4_lite_strb_merge (old word, new word, strobe -> merged word).
REQ-030 SHALL be drop-in attachable behind axi4_lite_interconnect slave ports via a thin adapter, with no AXI signal renaming inside.

Verification
REQ-031 SHALL test: AW+W same cycle, addr 0x08, data 0xDEADBEEF, strb 4'hF -> BVALID next cycle, BRESP OKAY, reg_q[2]=0xDEADBEEF.
REQ-032 SHALL test: W three cycles before AW, addr 0x04, strb 4'b0101, data 0xAABBCCDD onto 0x11223344 -> reg1=0x11BB33DD.
REQ-033 SHALL test: read addr 0x40 with NUM_REGS=8 -> RRESP SLVERR, RDATA 0; write there -> BRESP SLVERR, no reg change.
REQ-034 SHALL test: BREADY held low 5 cycles -> BVALID/BRESP stable, AWREADY=WREADY=0 throughout; second write accepted after B handshake.
REQ-035 SHALL test: read reg3 (0x5) in the same cycle its write to 0x9 completes -> RDATA 0x5; a subsequent read returns 0x9.
REQ-036 SHALL test: rst asserted in W_HAVE_ADDR -> no BVALID, registers 0, next full write completes normally.
